// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types, constants and op decode helpers for the multiply/divide unit
//
// Purpose : FSM state and funct3 op enums, the default operand width, the
//           special divide result patterns, and small op-classification helpers.
// Ports   : none (package)

package mdu_pkg;

    localparam int MDU_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    // Special divide results at the default width. Each pattern is uniform
    // (all ones / MSB only / zero), so the top rebuilds them at any XLEN.
    localparam logic [MDU_XLEN-1:0] MDU_DIV0_QUOT = '1;
    localparam logic [MDU_XLEN-1:0] MDU_OVF_QUOT  = {1'b1, {(MDU_XLEN-1){1'b0}}};
    localparam logic [MDU_XLEN-1:0] MDU_OVF_REM   = '0;

    function automatic logic op_signed_a(input mdu_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input mdu_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_is_div(input mdu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input mdu_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational iteration of shift-add multiply or restoring divide
//
// Purpose : Retires one product bit (LSB first) or one quotient bit (MSB first).
// Ports   : i_is_div  select divide step (1) or multiply step (0)
//           i_hi      partial product high half / partial remainder
//           i_lo      multiplier being consumed / dividend being consumed
//           i_opnd    multiplicand / divisor magnitude
//           o_hi      updated high half / remainder
//           o_lo      updated low half / quotient shifted in

module mdu_step #(
    parameter int W = 32
) (
    input  logic         i_is_div,
    input  logic [W-1:0] i_hi,
    input  logic [W-1:0] i_lo,
    input  logic [W-1:0] i_opnd,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    logic [W:0]   w_sum;
    logic [W:0]   w_shift;
    logic [W-1:0] w_diff;
    logic         w_ge;

    // Multiply: conditionally add the multiplicand, then shift {carry,hi,lo} right.
    assign w_sum   = {1'b0, i_hi} + {1'b0, (i_lo[0] ? i_opnd : {W{1'b0}})};

    // Divide: the remainder stays below the divisor, so the shifted trial value
    // needs one extra bit, and a successful subtract always fits back in W bits.
    assign w_shift = {i_hi, i_lo[W-1]};
    assign w_ge    = (w_shift >= {1'b0, i_opnd});
    assign w_diff  = w_shift[W-1:0] - i_opnd;

    always_comb begin
        o_hi = w_sum[W:1];
        o_lo = {w_sum[0], i_lo[W-1:1]};
        if (i_is_div) begin
            o_hi = w_ge ? w_diff : w_shift[W-1:0];
            o_lo = {i_lo[W-2:0], w_ge};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the execute stage
//
// Purpose : Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on unsigned magnitudes
//           over XLEN/BITS_PER_CYCLE cycles, fixing the sign at the end.
//           XLEN must be a multiple of BITS_PER_CYCLE (1, 2 or 4).
// Ports   : clk, rst         clock, synchronous active-high reset
//           in_valid/ready   op handshake (ready only when idle)
//           in_funct3        op select
//           in_opa, in_opb   rs1, rs2 values
//           in_tag           opaque tag returned with the result
//           flush            discard any in-flight op
//           out_valid/ready  result handshake
//           out_result       result value
//           out_tag          tag of the result
//           busy             op in flight or result waiting

module ex_muldiv_unit
    import mdu_pkg::*;
#(
    parameter int XLEN           = MDU_XLEN,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_opa,
    input  logic [XLEN-1:0]  in_opb,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int ITERS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LP_CNT_LOAD  = CNT_W'(ITERS - 1);
    localparam logic [XLEN-1:0]  LP_DIV0_QUOT = {XLEN{MDU_DIV0_QUOT[0]}};
    localparam logic [XLEN-1:0]  LP_OVF_QUOT  = {MDU_OVF_QUOT[MDU_XLEN-1], {(XLEN-1){MDU_OVF_QUOT[0]}}};
    localparam logic [XLEN-1:0]  LP_OVF_REM   = {XLEN{MDU_OVF_REM[0]}};

    mdu_state_t       r_state, w_next_state;
    mdu_op_t          r_op;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  r_hi, r_lo, r_opnd, r_result;
    logic             r_neg;
    logic [CNT_W-1:0] r_cnt;

    // Accept-side decode
    mdu_op_t         w_op;
    logic            w_sign_a, w_sign_b, w_res_neg, w_accept;
    logic            w_div0, w_ovf, w_special;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_res;

    assign w_op      = mdu_op_t'(in_funct3);
    assign w_sign_a  = op_signed_a(w_op) & in_opa[XLEN-1];
    assign w_sign_b  = op_signed_b(w_op) & in_opb[XLEN-1];
    assign w_mag_a   = w_sign_a ? -in_opa : in_opa;
    assign w_mag_b   = w_sign_b ? -in_opb : in_opb;
    // Remainder takes the dividend's sign; product and quotient the XOR.
    assign w_res_neg = op_is_rem(w_op) ? w_sign_a : (w_sign_a ^ w_sign_b);
    assign w_accept  = (r_state == ST_IDLE) & in_valid & ~flush;

    assign w_div0    = op_is_div(w_op) & (in_opb == '0);
    assign w_ovf     = ((w_op == OP_DIV) | (w_op == OP_REM)) & (in_opa == LP_OVF_QUOT) & (in_opb == '1);
    assign w_special = w_div0 | w_ovf;
    assign w_special_res = w_div0 ? (op_is_rem(w_op) ? in_opa : LP_DIV0_QUOT)
                                  : (op_is_rem(w_op) ? LP_OVF_REM : LP_OVF_QUOT);

    // Iteration chain: BITS_PER_CYCLE steps per clock
    logic [XLEN-1:0] w_hi [0:BITS_PER_CYCLE];
    logic [XLEN-1:0] w_lo [0:BITS_PER_CYCLE];
    logic            w_is_div;

    assign w_is_div = op_is_div(r_op);
    assign w_hi[0]  = r_hi;
    assign w_lo[0]  = r_lo;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_chain
        mdu_step #(.W(XLEN)) u_step (
            .i_is_div (w_is_div),
            .i_hi     (w_hi[g]),
            .i_lo     (w_lo[g]),
            .i_opnd   (r_opnd),
            .o_hi     (w_hi[g+1]),
            .o_lo     (w_lo[g+1])
        );
    end

    // Sign correction on the final iteration's outputs
    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [XLEN-1:0]   w_div_raw, w_div_fix, w_final;

    assign w_prod     = {w_hi[BITS_PER_CYCLE], w_lo[BITS_PER_CYCLE]};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_div_raw  = op_is_rem(r_op) ? w_hi[BITS_PER_CYCLE] : w_lo[BITS_PER_CYCLE];
    assign w_div_fix  = r_neg ? -w_div_raw : w_div_raw;
    assign w_final    = w_is_div          ? w_div_fix :
                        (r_op == OP_MUL)  ? w_prod_fix[XLEN-1:0] :
                                            w_prod_fix[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next_state = w_special ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (flush) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_tag    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op   <= w_op;
            r_tag  <= in_tag;
            r_hi   <= '0;
            r_lo   <= w_mag_a;
            r_opnd <= w_mag_b;
            r_neg  <= w_res_neg;
            r_cnt  <= LP_CNT_LOAD;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == ST_BUSY) begin
            r_hi <= w_hi[BITS_PER_CYCLE];
            r_lo <= w_lo[BITS_PER_CYCLE];
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else if (!flush) begin
                r_result <= w_final;
            end
        end
    end

    assign out_result = r_result;
    assign out_tag    = r_tag;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit against an arithmetic model

module tb_ex_muldiv_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_opa, in_opb;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    ex_muldiv_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_opa     (in_opa),
        .in_opb     (in_opb),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          due;
    } exp_t;
    exp_t exp_q[$];
    bit   front_seen = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Architectural RV32M results from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        p  = '0;
        case (op)
            3'b000: begin p = ua * ub;          return p[31:0];  end
            3'b001: begin p = sa * sb;          return p[63:32]; end
            3'b010: begin p = sa * longint'(ub); return p[63:32]; end
            3'b011: begin p = ua * ub;          return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Compare process: occupancy, latency, result and tag against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", busy, exp_q.size() != 0);
            chk("in_ready", in_ready, exp_q.size() == 0);
            if (exp_q.size() == 0) begin
                chk("out_valid_idle", out_valid, 1'b0);
            end else if (out_valid) begin
                if (!front_seen) begin
                    chk("latency", cyc, exp_q[0].due);
                    front_seen = 1'b1;
                end
                chk("result", out_result, exp_q[0].res);
                chk("tag", out_tag, exp_q[0].tag);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    front_seen = 1'b0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int g;
        exp_t e;
        g = 0;
        while (!in_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: in_ready stayed 0");
        end
        in_valid  = 1'b1;
        in_funct3 = op;
        in_opa    = a;
        in_opb    = b;
        in_tag    = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.res = model(op, a, b);
        e.tag = tag;
        e.due = cyc + (is_special(op, a, b) ? 0 : 32);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
            exp_q.delete();
            front_seen = 1'b0;
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int g;
        rst = 1'b1; in_valid = 1'b0; in_funct3 = '0; in_opa = '0; in_opb = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b1;

        vecs.push_back('{3'b000, 32'd7,          32'd6,          5'd3,  32'd42});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'h0000_0000});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  32'hFFFF_FFFE});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'hFFFF_FFFF});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF});
        vecs.push_back('{3'b101, 32'd100,        32'd7,          5'd9,  32'd14});
        vecs.push_back('{3'b111, 32'd100,        32'd7,          5'd10, 32'd2});
        vecs.push_back('{3'b101, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF});
        vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h0});
        vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000});
        vecs.push_back('{3'b111, 32'd5,          32'd0,          5'd14, 32'd5});
        vecs.push_back('{3'b100, 32'd7,          32'hFFFF_FFFE,  5'd15, 32'hFFFF_FFFD});
        vecs.push_back('{3'b110, 32'd7,          32'hFFFF_FFFE,  5'd16, 32'd1});
        vecs.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000,  5'd17, 32'h4000_0000});
        vecs.push_back('{3'b011, 32'h8000_0000,  32'd4,          5'd18, 32'd2});
        vecs.push_back('{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd19, 32'd0});
        vecs.push_back('{3'b100, 32'd0,          32'd0,          5'd20, 32'hFFFF_FFFF});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_out_result", out_result, 32'h0);
        chk("reset_out_tag", out_tag, 5'h0);
        @(posedge clk); #1;

        // Pin the model to hand-computed values
        foreach (vecs[i]) chk($sformatf("model_vec%0d", i), model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);

        // Directed vectors through the DUT
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            count_busy(n);
            chk($sformatf("busy_cycles_vec%0d", i), n, is_special(vecs[i].op, vecs[i].a, vecs[i].b) ? 1 : 33);
            drain();
        end

        // flush coinciding with in_valid in IDLE: op must not be taken
        in_valid = 1'b1; in_funct3 = 3'b000; in_opa = 32'd9; in_opb = 32'd9; in_tag = 5'd21; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // flush in BUSY cycle 5: discarded, no out_valid afterwards
        issue(3'b000, 32'd3, 32'd5, 5'd22);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        front_seen = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // Consumer stalls for 4 cycles in DONE
        out_ready = 1'b0;
        issue(3'b101, 32'd100, 32'd7, 5'd23);
        g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("hold_reached_done", out_valid, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("hold_busy", busy, 1'b1);
            chk("hold_result", out_result, 32'd14);
            chk("hold_tag", out_tag, 5'd23);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Reset at BUSY cycle 10 of a DIV
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd24);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        front_seen = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_result", out_result, 32'h0);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk); #1;

        // Unit still works after the mid-op reset
        issue(3'b000, 32'hFFFF_FFFF, 32'd2, 5'd25);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
